// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake bundle between the message clients, the UART transmit
// arbiter and the UART transmitter, plus the arbiter's status outputs.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_valid;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          timeout_pulse;

    // Environment side: clients and transmitter drive, arbiter outputs observed.
    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant, busy, timeout_pulse
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant, busy, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter handing the shared UART transmit byte stream to one client
// for a whole message; an optional idle timeout reclaims a stalled grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]            r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [IDX_W-1:0]      r_last_grant;
    logic                  r_timeout_pulse;

    logic                  w_found;
    logic [IDX_W-1:0]      w_winner;
    logic [NUM_REQ-1:0]    w_winner_oh;
    logic                  w_own_valid;
    logic                  w_own_last;
    logic [DATA_WIDTH-1:0] w_own_data;
    logic                  w_last_xfer;
    logic                  w_expire;

    // Rotating priority: indices above last_grant win first, then wrap to index 0.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch can form.
        w_found     = 1'b0;
        w_winner    = r_last_grant;
        w_winner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req_valid[i] && (IDX_W'(i) > r_last_grant)) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req_valid[i]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_winner_oh[i] = (IDX_W'(i) == w_winner);
        end
    end

    // The registered one-hot grant steers the owner's lane; all zero while idle.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_own_valid = bus.req_valid[i];
                w_own_last  = bus.req_last[i];
                w_own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_last_xfer = w_own_valid && w_own_last && bus.tx_ready;

    // Reset blanks the handshake immediately, before the grant register clears.
    assign bus.tx_valid      = w_own_valid && !reset;
    assign bus.tx_data       = w_own_data;
    assign bus.req_ready     = reset ? '0 : (r_grant & {NUM_REQ{bus.tx_ready}});
    assign bus.grant         = r_grant;
    assign bus.busy          = (r_state == ST_OWN);
    assign bus.timeout_pulse = r_timeout_pulse;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            logic [CNT_W-1:0] r_idle_cnt;

            // Expiry leaves OWN, so the counter stops at TIMEOUT_CYCLES-1 and never wraps.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_idle_cnt <= '0;
                end else if ((r_state != ST_OWN) || w_own_valid) begin
                    r_idle_cnt <= '0;
                end else if (!w_expire) begin
                    r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                end
            end

            assign w_expire = (r_state == ST_OWN) && !w_own_valid &&
                              (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments only, so every reader sees pre-edge values.
        if (reset) begin
            r_state         <= ST_IDLE;
            r_grant         <= '0;
            r_last_grant    <= IDX_W'(NUM_REQ - 1);
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state      <= ST_OWN;
                        r_grant      <= w_winner_oh;
                        r_last_grant <= w_winner;
                    end
                end
                ST_OWN: begin
                    // A transfer clears the idle counter, so these two never coincide.
                    if (w_last_xfer || w_expire) begin
                        r_state         <= ST_IDLE;
                        r_grant         <= '0;
                        r_timeout_pulse <= w_expire;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end
endmodule
